// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / mul-div block: ALUCtrl codes,
// main-decoder ALUOp classes, R-type funct values and the FSM state type.
package alu_ctrl_pkg;

  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned MD_OP_W = 2;

  // ALUCtrl operation codes
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_C4   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_C1   = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SRAV = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_C2   = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_C6   = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_NONE = 4'b1111;

  // Main-decoder ALUOp classes
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_C1    = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_C2    = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_C3    = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_C4    = 3'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_C5    = 3'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_C6    = 3'd6;

  // R-type funct values
  localparam logic [FUNCT_W-1:0] F_SRA   = 6'd3;
  localparam logic [FUNCT_W-1:0] F_SRAV  = 6'd7;
  localparam logic [FUNCT_W-1:0] F_MFHI  = 6'd16;
  localparam logic [FUNCT_W-1:0] F_MFLO  = 6'd18;
  localparam logic [FUNCT_W-1:0] F_MULT  = 6'd24;
  localparam logic [FUNCT_W-1:0] F_MULTU = 6'd25;
  localparam logic [FUNCT_W-1:0] F_DIV   = 6'd26;
  localparam logic [FUNCT_W-1:0] F_DIVU  = 6'd27;
  localparam logic [FUNCT_W-1:0] F_ADD   = 6'd32;
  localparam logic [FUNCT_W-1:0] F_ADDU  = 6'd33;
  localparam logic [FUNCT_W-1:0] F_SUB   = 6'd34;
  localparam logic [FUNCT_W-1:0] F_SUBU  = 6'd35;
  localparam logic [FUNCT_W-1:0] F_AND   = 6'd36;
  localparam logic [FUNCT_W-1:0] F_OR    = 6'd37;
  localparam logic [FUNCT_W-1:0] F_XOR   = 6'd38;
  localparam logic [FUNCT_W-1:0] F_NOR   = 6'd39;
  localparam logic [FUNCT_W-1:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle multiply/divide engine.
// Ports: clk, rst_n (async active-low), start (latch operands), op
// ({div, unsigned}), src1/src2 operands; done_c is high in the last
// iteration cycle, hi_c/lo_c carry the sign-corrected result once done.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  output logic               done_c,
  output logic [DATA_W-1:0]  hi_c,
  output logic [DATA_W-1:0]  lo_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic              run;
  logic [CNT_W-1:0]  cnt;
  logic              is_div;
  logic              neg_res;   // negate product / quotient
  logic              neg_rem;   // negate remainder (dividend sign)
  logic              div0;
  logic [DATA_W-1:0] dvd_raw;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              s1n, s2n;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W:0]   msum, dshift, ddiff;
  logic [2*DATA_W-1:0] prod;

  // Operand magnitudes, one iteration step, and final sign correction
  always_comb begin
    s1n    = ~op[0] & src1[DATA_W-1];
    s2n    = ~op[0] & src2[DATA_W-1];
    mag1   = s1n ? -src1 : src1;
    mag2   = s2n ? -src2 : src2;
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : (DATA_W+1)'(0));
    dshift = {hi_q, lo_q[DATA_W-1]};
    ddiff  = dshift - {1'b0, b_q};
    prod   = neg_res ? -{hi_q, lo_q} : {hi_q, lo_q};
    hi_c   = prod[2*DATA_W-1:DATA_W];
    lo_c   = prod[DATA_W-1:0];
    if (is_div) begin
      if (div0) begin
        hi_c = dvd_raw;
        lo_c = '1;
      end else begin
        hi_c = neg_rem ? -hi_q : hi_q;
        lo_c = neg_res ? -lo_q : lo_q;
      end
    end
    done_c = run & (cnt == CNT_W'(DATA_W - 1));
  end

  // Operand latch and shift-add / restoring-divide iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      dvd_raw <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      is_div  <= op[1];
      neg_res <= s1n ^ s2n;
      neg_rem <= s1n;
      div0    <= (src2 == '0);
      dvd_raw <= src1;
      b_q     <= mag2;
      hi_q    <= '0;
      lo_q    <= mag1;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
      if (done_c) run <= 1'b0;
      if (is_div) begin
        // borrow out of the trial subtraction means restore
        if (!ddiff[DATA_W]) begin
          hi_q <= ddiff[DATA_W-1:0];
          lo_q <= {lo_q[DATA_W-2:0], 1'b1};
        end else begin
          hi_q <= dshift[DATA_W-1:0];
          lo_q <= {lo_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {msum, lo_q[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with multi-cycle mult/div unit and HI/LO registers.
// Ports: clk_i, rst_i (async active-low), funct_i, ALUOp_i, valid_i,
// src1_i/src2_i operands; ALUCtrl_o, shamt_select_o, illegal_o (decode),
// stall_o (pipeline hold), hilo_o/hilo_sel_o (mfhi/mflo writeback).
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               shamt_select_o,
  output logic               stall_o,
  output logic [DATA_W-1:0]  hilo_o,
  output logic               hilo_sel_o,
  output logic               illegal_o
);

  localparam logic MD_EN = (MULDIV_EN != 0);

  state_t            state;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              just_done;   // blocks restart by the held instruction
  logic              bad;
  logic              is_start_c, is_mfhilo_c, start_c;
  logic              eng_done;
  logic [DATA_W-1:0] eng_hi, eng_lo;

  // ALU operation decode
  always_comb begin
    ALUCtrl_o      = ALU_NONE;
    shamt_select_o = 1'b0;
    bad            = 1'b1;
    case (ALUOp_i)
      ALUOP_RTYPE: begin
        case (funct_i)
          F_SRA:  begin ALUCtrl_o = ALU_SRA;  bad = 1'b0; shamt_select_o = 1'b1; end
          F_SRAV: begin ALUCtrl_o = ALU_SRAV; bad = 1'b0; end
          F_ADD:  begin ALUCtrl_o = ALU_ADD;  bad = 1'b0; end
          F_SUB:  begin ALUCtrl_o = ALU_SUB;  bad = 1'b0; end
          F_AND:  begin ALUCtrl_o = ALU_AND;  bad = 1'b0; end
          F_OR:   begin ALUCtrl_o = ALU_OR;   bad = 1'b0; end
          F_SLT:  begin ALUCtrl_o = ALU_SLT;  bad = 1'b0; end
          F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU: bad = ~MD_EN;
          default: ;
        endcase
      end
      ALUOP_C1: begin ALUCtrl_o = ALU_C1;  bad = 1'b0; end
      ALUOP_C2: begin ALUCtrl_o = ALU_C2;  bad = 1'b0; end
      ALUOP_C3: begin ALUCtrl_o = ALU_ADD; bad = 1'b0; end
      ALUOP_C4: begin ALUCtrl_o = ALU_C4;  bad = 1'b0; end
      ALUOP_C5: begin ALUCtrl_o = ALU_OR;  bad = 1'b0; end
      ALUOP_C6: begin ALUCtrl_o = ALU_C6;  bad = 1'b0; end
      default: ;
    endcase
    illegal_o = valid_i & bad;
  end

  // Engine handshake, stall and HI/LO read path
  always_comb begin
    is_start_c  = MD_EN && (ALUOp_i == ALUOP_RTYPE) && (funct_i[5:2] == 4'b0110);
    is_mfhilo_c = MD_EN && (ALUOp_i == ALUOP_RTYPE) &&
                  ((funct_i == F_MFHI) || (funct_i == F_MFLO));
    start_c     = rst_i & valid_i & is_start_c & (state == ST_IDLE) & ~just_done;
    stall_o     = rst_i & valid_i & (start_c | (state != ST_IDLE));
    hilo_sel_o  = is_mfhilo_c & (state == ST_IDLE);
    hilo_o      = (funct_i == F_MFHI) ? hi_q : lo_q;
  end

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.DATA_W(DATA_W)) u_md (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .start  (start_c),
        .op     (funct_i[MD_OP_W-1:0]),
        .src1   (src1_i),
        .src2   (src2_i),
        .done_c (eng_done),
        .hi_c   (eng_hi),
        .lo_c   (eng_lo)
      );
    end else begin : g_no_md
      assign eng_done = 1'b0;
      assign eng_hi   = '0;
      assign eng_lo   = '0;
    end
  endgenerate

  // Control FSM and HI/LO registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      just_done <= 1'b0;
    end else begin
      just_done <= (state == ST_FIX);
      case (state)
        ST_IDLE: if (start_c) state <= ST_BUSY;
        ST_BUSY: if (eng_done) state <= ST_FIX;
        ST_FIX: begin
          hi_q  <= eng_hi;
          lo_q  <= eng_lo;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: decode sweep, mul/div results via a
// scoreboard queue, latency, mflo-during-busy and mid-operation reset.
module tb_alu_ctrl_mc;

  localparam int unsigned W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [5:0]    funct_i;
  logic [2:0]    ALUOp_i;
  logic          valid_i;
  logic [W-1:0]  src1_i, src2_i;
  logic [3:0]    ALUCtrl_o;
  logic          shamt_select_o, stall_o, hilo_sel_o, illegal_o;
  logic [W-1:0]  hilo_o;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  logic [5:0]  dec_q[$];

  alu_ctrl_mc #(.DATA_W(W), .MULDIV_EN(1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .funct_i        (funct_i),
    .ALUOp_i        (ALUOp_i),
    .valid_i        (valid_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .ALUCtrl_o      (ALUCtrl_o),
    .shamt_select_o (shamt_select_o),
    .stall_o        (stall_o),
    .hilo_o         (hilo_o),
    .hilo_sel_o     (hilo_sel_o),
    .illegal_o      (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dec_model(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'd0) begin
      case (f)
        6'd3:  return 5'b0_1000;
        6'd7:  return 5'b0_1001;
        6'd32: return 5'b0_0010;
        6'd34: return 5'b0_0110;
        6'd36: return 5'b0_0000;
        6'd37: return 5'b0_0001;
        6'd42: return 5'b0_0100;
        default: return 5'b1_1111;
      endcase
    end
    case (op)
      3'd1: return 5'b0_0111;
      3'd2: return 5'b0_1010;
      3'd3: return 5'b0_0010;
      3'd4: return 5'b0_0011;
      3'd5: return 5'b0_0001;
      3'd6: return 5'b0_1011;
      default: return 5'b1_1111;
    endcase
  endfunction

  // Reference result {HI, LO} from native SystemVerilog arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int q, r;
    case (f)
      6'd24: begin sp = longint'($signed(a)) * longint'($signed(b)); return 64'(sp); end
      6'd25: begin up = {32'b0, a} * {32'b0, b}; return up; end
      6'd26: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      6'd27: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic read_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = 6'd16;
    #1;
    check({tag, " mfhi sel"}, 64'(hilo_sel_o), 64'd1);
    check({tag, " mfhi stall"}, 64'(stall_o), 64'd0);
    check({tag, " HI"}, 64'(hilo_o), 64'(e[63:32]));
    @(negedge clk_i);
    funct_i = 6'd18;
    #1;
    check({tag, " LO"}, 64'(hilo_o), 64'(e[31:0]));
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e);
    int n;
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = f; src1_i = a; src2_i = b;
    exp_q.push_back(e);
    #1;
    check({tag, " start stall"}, 64'(stall_o), 64'd1);
    check({tag, " start ctrl"}, 64'(ALUCtrl_o), 64'hF);
    check({tag, " start illegal"}, 64'(illegal_o), 64'd0);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (!stall_o) break;
      n++;
    end
    check({tag, " stall cycles"}, 64'(n), 64'd34);
    read_hilo(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] functs [8];
    logic [4:0] d;
    logic [5:0] got;
    logic [5:0] e6;
    functs = '{6'd3, 6'd7, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};

    // Reset: start-class instruction present but no stall, HI reads 0
    rst_i = 1'b0; valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = 6'd24;
    src1_i = 32'd9; src2_i = 32'd4;
    #2;
    check("reset stall", 64'(stall_o), 64'd0);
    funct_i = 6'd16; #1;
    check("reset hi", 64'(hilo_o), 64'd0);
    check("reset hilo_sel", 64'(hilo_sel_o), 64'd1);
    funct_i = 6'd32; #1;
    check("reset ctrl follows", 64'(ALUCtrl_o), 64'h2);
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0;

    // Decode sweep
    for (int op = 0; op < 8; op++) begin
      for (int fi = 0; fi < 8; fi++) begin
        @(negedge clk_i);
        valid_i = 1'b1; ALUOp_i = 3'(op); funct_i = functs[fi];
        d = dec_model(3'(op), functs[fi]);
        dec_q.push_back({(op == 0 && functs[fi] == 6'd3), d});
        #1;
        got = {shamt_select_o, illegal_o, ALUCtrl_o};
        e6 = dec_q.pop_front();
        check($sformatf("decode op%0d f%0d", op, functs[fi]), 64'(got), 64'(e6));
      end
    end

    // valid_i low suppresses illegal, stall and starts
    @(negedge clk_i);
    valid_i = 1'b0; ALUOp_i = 3'd7; funct_i = 6'd24; #1;
    check("invalid illegal", 64'(illegal_o), 64'd0);
    ALUOp_i = 3'd0; #1;
    check("invalid stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    valid_i = 1'b1; funct_i = 6'd16; #1;
    check("no start when invalid", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    valid_i = 1'b0;

    // Directed mul/div vectors
    run_op("mult -2*3", 6'd24, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("divu 100/7", 6'd27, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div -7/2", 6'd26, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div 5/0", 6'd26, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op("div minneg/-1", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    run_op("multu max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           model(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_op("divu mixed", 6'd27, 32'hDEAD_BEEF, 32'h1234,
           model(6'd27, 32'hDEAD_BEEF, 32'h1234));
    run_op("div neg/neg", 6'd26, 32'hFFFF_FC18, 32'hFFFF_FFF9,
           model(6'd26, 32'hFFFF_FC18, 32'hFFFF_FFF9));

    // mflo issued one cycle after a mult starts
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = 6'd25;
    src1_i = 32'h1234_5678; src2_i = 32'h9ABC_DEF0;
    exp_q.push_back(model(6'd25, 32'h1234_5678, 32'h9ABC_DEF0));
    #1;
    check("mflo-busy start stall", 64'(stall_o), 64'd1);
    @(negedge clk_i);
    funct_i = 6'd18; #1;
    check("mflo-busy stall", 64'(stall_o), 64'd1);
    check("mflo-busy sel", 64'(hilo_sel_o), 64'd0);
    n = 2;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (!stall_o) break;
      n++;
    end
    check("mflo-busy stall cycles", 64'(n), 64'd34);
    check("mflo-busy sel after", 64'(hilo_sel_o), 64'd1);
    check("mflo-busy LO", 64'(hilo_o), 64'(exp_q[0][31:0]));
    read_hilo("mflo-busy");

    // Reset in BUSY cycle 10 aborts without writing HI/LO
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = 6'd24;
    src1_i = 32'h0000_1234; src2_i = 32'h0000_5678;
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    rst_i = 1'b0; #1;
    check("abort stall", 64'(stall_o), 64'd0);
    funct_i = 6'd16; #1;
    check("abort hi", 64'(hilo_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0;
    exp_q.push_back(64'd0);
    read_hilo("after abort");
    run_op("mult 7*-3", 6'd24, 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
